clock_display: RTL and testbench

Display driver for the time-of-day counter: consumes the binary `minute` (0–59) and `hour` (0–23) words and drives a 4-digit multiplexed seven-segment display in HH:MM form. Each display frame starts with a coherent snapshot of both inputs. The block converts the snapshot to BCD with a small sequential subtract-by-10 engine, then scans the digits at a programmable rate. It sits between the counter's outputs and the board's segment/anode pins.

---
 rtl/clock_display.sv | 168 ++++++++++++++++
 tb/tb_clock_display.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display.sv
`default_nettype none
// ============================================================================
// Module      : clock_display
// Description : HH:MM multiplexed seven-segment driver. Takes a frame-coherent
//               snapshot of binary minute/hour and converts it to BCD with a
//               sequential subtract-by-10 engine. Then it scans the four digits
//               at a programmable rate.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_display #(
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] minute,
    input  logic [4:0] hour,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic [1:0] range_err
);

    localparam int               c_div_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [3:0]       c_dash     = 4'hA;
    localparam logic [6:0]       c_seg_inv  = {7{ACTIVE_LOW}};
    localparam logic [3:0]       c_an_inv   = {4{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_div_w-1:0]  r_div;
    logic [1:0]          r_dig;
    logic                r_pend;
    logic [5:0]          r_rem_m;
    logic [4:0]          r_rem_h;
    logic [2:0]          r_tens_m;
    logic [1:0]          r_tens_h;
    logic                r_oor_m;
    logic                r_oor_h;
    logic [3:0][3:0]     r_digits;

    logic w_div_tc;
    logic w_wrap;
    logic w_req;
    logic w_m_busy;
    logic w_h_busy;

    assign w_div_tc = (r_div == c_div_last);
    assign w_wrap   = w_div_tc && (r_dig == 2'd3);
    assign w_req    = r_pend || w_wrap;
    // A field keeps subtracting only while it is in range and still >= 10
    assign w_m_busy = !r_oor_m && (r_rem_m >= 6'd10);
    assign w_h_busy = !r_oor_h && (r_rem_h >= 5'd10);

    // Active-high segment pattern {g,f,e,d,c,b,a}; any non-decimal code is a dash
    function automatic logic [6:0] f_pattern(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    // Scan divider and digit index; the digit advances on the divider terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_dig <= 2'd0;
        end else if (w_div_tc) begin
            r_div <= '0;
            r_dig <= r_dig + 2'd1;
        end else begin
            r_div <= r_div + c_div_w'(1);
        end
    end

    // Snapshot / binary-to-BCD converter; requests that arrive while busy stay pending
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pend    <= 1'b1;
            r_rem_m   <= 6'd0;
            r_rem_h   <= 5'd0;
            r_tens_m  <= 3'd0;
            r_tens_h  <= 2'd0;
            r_oor_m   <= 1'b0;
            r_oor_h   <= 1'b0;
            r_digits  <= '0;
            range_err <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_rem_m  <= minute;
                        r_rem_h  <= hour;
                        r_tens_m <= 3'd0;
                        r_tens_h <= 2'd0;
                        r_oor_m  <= (minute > 6'd59);
                        r_oor_h  <= (hour > 5'd23);
                        r_pend   <= 1'b0;
                        r_state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (w_wrap) begin
                        r_pend <= 1'b1;
                    end
                    if (!w_m_busy && !w_h_busy) begin
                        r_state <= S_COMMIT;
                    end
                    if (w_m_busy) begin
                        r_rem_m  <= r_rem_m - 6'd10;
                        r_tens_m <= r_tens_m + 3'd1;
                    end
                    if (w_h_busy) begin
                        r_rem_h  <= r_rem_h - 5'd10;
                        r_tens_h <= r_tens_h + 2'd1;
                    end
                end
                S_COMMIT: begin
                    if (w_wrap) begin
                        r_pend <= 1'b1;
                    end
                    r_digits[0] <= r_oor_m ? c_dash : r_rem_m[3:0];
                    r_digits[1] <= r_oor_m ? c_dash : {1'b0, r_tens_m};
                    r_digits[2] <= r_oor_h ? c_dash : r_rem_h[3:0];
                    r_digits[3] <= r_oor_h ? c_dash : {2'b00, r_tens_h};
                    range_err   <= {r_oor_h, r_oor_m};
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered pin drivers: segment pattern, one-hot anode and colon for digit dig
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= c_seg_inv;
            an  <= c_an_inv;
            dp  <= ACTIVE_LOW;
        end else begin
            seg <= f_pattern(r_digits[r_dig]) ^ c_seg_inv;
            an  <= (4'b0001 << r_dig) ^ c_an_inv;
            dp  <= (r_dig == 2'd2) ^ ACTIVE_LOW;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_display
// Description : Directed self-checking bench for clock_display (SCAN_DIV=16,
//               ACTIVE_LOW=1). cyc counts clock edges since the last reset
//               release, so every frame boundary sits at a multiple of 64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] minute;
    logic [4:0] hour;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic [1:0] range_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    clock_display #(
        .SCAN_DIV   (16),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .minute    (minute),
        .hour      (hour),
        .seg       (seg),
        .an        (an),
        .dp        (dp),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    // Edge count since reset release
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected active-low segment value; code 10 is the dash
    function automatic logic [6:0] ref_seg(input int code);
        logic [6:0] pat;
        case (code)
            0:       pat = 7'h3F;
            1:       pat = 7'h06;
            2:       pat = 7'h5B;
            3:       pat = 7'h4F;
            4:       pat = 7'h66;
            5:       pat = 7'h6D;
            6:       pat = 7'h7D;
            7:       pat = 7'h07;
            8:       pat = 7'h7F;
            9:       pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return ~pat;
    endfunction

    // Advance to the negedge following edge k
    task automatic wait_cyc(input int k);
        int guard = 0;
        while (cyc < k && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != k) check("schedule", cyc, k);
    endtask

    task automatic check_digit(input int base, input int i, input logic [6:0] exp_seg,
                               input logic [1:0] exp_err);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << i);
        wait_cyc(base + 16 * i + 10);
        check($sformatf("seg d%0d frame%0d", i, base), seg, exp_seg);
        check($sformatf("an d%0d frame%0d", i, base), an, exp_an);
        check($sformatf("dp d%0d frame%0d", i, base), dp, (i == 2) ? 0 : 1);
        check($sformatf("range_err d%0d frame%0d", i, base), range_err, exp_err);
    endtask

    task automatic check_frame_val(input int base, input int m, input int h);
        int         mc0, mc1, hc0, hc1;
        logic [1:0] err;
        err = {(h > 23), (m > 59)};
        mc0 = (m > 59) ? 10 : m % 10;
        mc1 = (m > 59) ? 10 : m / 10;
        hc0 = (h > 23) ? 10 : h % 10;
        hc1 = (h > 23) ? 10 : h / 10;
        check_digit(base, 0, ref_seg(mc0), err);
        check_digit(base, 1, ref_seg(mc1), err);
        check_digit(base, 2, ref_seg(hc0), err);
        check_digit(base, 3, ref_seg(hc1), err);
    endtask

    initial begin
        int base;
        int m;
        int h;
        rst    = 1'b1;
        minute = 6'd0;
        hour   = 5'd0;
        repeat (3) @(negedge clk);
        check("reset seg", seg, 7'h7F);
        check("reset an", an, 4'hF);
        check("reset dp", dp, 1'b1);
        check("reset range_err", range_err, 2'b00);
        rst = 1'b0;

        // Frame 0: 00:00, anode scan order and colon
        wait_cyc(1);
        check("first seg", seg, 7'h40);
        check("first an", an, 4'hE);
        check("first dp", dp, 1'b1);
        wait_cyc(16);
        check("an hold d0", an, 4'hE);
        wait_cyc(17);
        check("an d1", an, 4'hD);
        check("seg d1 zero", seg, 7'h40);
        wait_cyc(33);
        check("an d2", an, 4'hB);
        check("dp colon", dp, 1'b0);
        check("seg d2 zero", seg, 7'h40);
        wait_cyc(49);
        check("an d3", an, 4'h7);
        check("dp d3", dp, 1'b1);
        minute = 6'd59;
        hour   = 5'd23;

        // Frame 64: 23:59, worst-case latency (seg changes exactly at T+8)
        wait_cyc(65);
        check("an wrap", an, 4'hE);
        check("stale d0", seg, 7'h40);
        wait_cyc(71);
        check("latency T+7", seg, 7'h40);
        wait_cyc(72);
        check("latency T+8", seg, 7'h10);
        check("range_err 23:59", range_err, 2'b00);
        check_digit(64, 1, 7'h12, 2'b00);
        check_digit(64, 2, 7'h30, 2'b00);
        check_digit(64, 3, 7'h24, 2'b00);
        minute = 6'd62;
        hour   = 5'd7;

        // Frame 128: minute out of range
        check_digit(128, 0, 7'h3F, 2'b01);
        check_digit(128, 1, 7'h3F, 2'b01);
        check_digit(128, 2, 7'h78, 2'b01);
        check_digit(128, 3, 7'h40, 2'b01);
        minute = 6'd9;
        hour   = 5'd0;

        // Frame 192: 00:09, minute changes to 10 mid-frame without tearing
        check_digit(192, 0, 7'h10, 2'b00);
        minute = 6'd10;
        check_digit(192, 1, 7'h40, 2'b00);
        check_digit(192, 2, 7'h40, 2'b00);
        check_digit(192, 3, 7'h40, 2'b00);
        check_digit(256, 0, 7'h40, 2'b00);
        check_digit(256, 1, 7'h79, 2'b00);
        check_digit(256, 2, 7'h40, 2'b00);
        check_digit(256, 3, 7'h40, 2'b00);
        minute = 6'd45;
        hour   = 5'd18;

        // Snapshot of 18:45 at edge 320, reset two cycles later aborts it
        wait_cyc(322);
        rst = 1'b1;
        @(negedge clk);
        check("abort seg", seg, 7'h7F);
        check("abort an", an, 4'hF);
        check("abort dp", dp, 1'b1);
        check("abort range_err", range_err, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // Forced snapshot after release: 4 tens -> commit at T+6, seg at T+8 is T+7 here
        wait_cyc(1);
        check("post-reset digit reg", seg, 7'h40);
        wait_cyc(7);
        check("post-reset T+7 stale", seg, 7'h40);
        wait_cyc(8);
        check("post-reset d0", seg, 7'h12);
        check_digit(0, 1, 7'h19, 2'b00);
        check_digit(0, 2, 7'h00, 2'b00);
        check_digit(0, 3, 7'h79, 2'b00);
        minute = 6'd30;
        hour   = 5'd25;

        // Frame 64: hour out of range
        check_digit(64, 0, 7'h40, 2'b10);
        check_digit(64, 1, 7'h30, 2'b10);
        check_digit(64, 2, 7'h3F, 2'b10);
        check_digit(64, 3, 7'h3F, 2'b10);

        // Sweep covering every minute value and every hour value
        base = 128;
        for (int k = 0; k < 60; k++) begin
            m      = (k * 7) % 60;
            h      = (k * 5) % 24;
            minute = 6'(m);
            hour   = 5'(h);
            check_frame_val(base, m, h);
            base += 64;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
